// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART transmit and receive stages.
//   UART_BAUD_DIV   : clocks per bit at 50 MHz for 115200 baud.
//   UART_FRAME_BITS : bits per 8N1 frame (start + 8 data + stop).
//   tx_state_t      : transmit controller states.
package uart_pkg;

  localparam int UART_BAUD_DIV   = 434;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    LATCH,
    SEND
  } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter shared by the UART transmit and receive stages.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset
//   run     : counter advances while high, held at 0 while low
//   bit_end : high on the last clock of each bit period
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);

  localparam int              CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] baud_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || !run || bit_end) begin
      baud_cnt_reg <= '0;
    end else begin
      baud_cnt_reg <= baud_cnt_reg + 1'b1;
    end
  end

  // Gated with run so a stale count can never end a bit outside a frame.
  assign bit_end = run && (baud_cnt_reg == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: pops bytes from the SDRAM read FIFO and sends each as an 8N1
// UART frame, LSB first.
// Ports:
//   clk         : system clock (50 MHz)
//   rst         : synchronous active-high reset
//   tx_en       : permission to start new frames (a running frame always completes)
//   rfifo_empty : read FIFO empty flag, sampled only when idle
//   rfifo_data  : read FIFO output, valid the cycle after the pop strobe
//   rfifo_rd    : one-cycle registered pop strobe
//   rs232_tx    : serial line, registered, idles high
//   tx_busy     : high from pop until the end of the stop bit
//   tx_done     : one-cycle pulse in the first idle cycle after the stop bit
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              rfifo_empty,
  input  logic [DATA_W-1:0] rfifo_data,
  output logic              rfifo_rd,
  output logic              rs232_tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

  tx_state_t         state_reg;
  logic [3:0]        bit_idx_reg;
  // Payload plus the stop bit above it: shifting right walks d[0]..d[7] then 1.
  logic [DATA_W:0]   shift_reg;
  logic              baud_run;
  logic              bit_end;

  assign baud_run = (state_reg == SEND);

  uart_baud_cnt #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .run     (baud_run),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rfifo_rd    <= 1'b0;
      rs232_tx    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      bit_idx_reg <= '0;
      shift_reg   <= '1;
    end else begin
      rfifo_rd <= 1'b0;
      tx_done  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tx_en && !rfifo_empty) begin
            state_reg <= RD;
            rfifo_rd  <= 1'b1;
            tx_busy   <= 1'b1;
          end
        end
        RD: begin
          state_reg <= LATCH;
        end
        LATCH: begin
          // FIFO output is valid now; start bit goes out next cycle.
          state_reg   <= SEND;
          shift_reg   <= {1'b1, rfifo_data};
          rs232_tx    <= 1'b0;
          bit_idx_reg <= '0;
        end
        SEND: begin
          if (bit_end) begin
            if (bit_idx_reg == LAST_BIT) begin
              state_reg <= IDLE;
              tx_done   <= 1'b1;
              tx_busy   <= 1'b0;
              rs232_tx  <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              rs232_tx    <= shift_reg[0];
              shift_reg   <= {1'b1, shift_reg[DATA_W:1]};
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  localparam int B = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       rfifo_empty = 1'b1;
  logic [7:0] rfifo_data = 8'h00;
  logic       rfifo_rd;
  logic       rs232_tx;
  logic       tx_busy;
  logic       tx_done;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .BAUD_DIV (B),
    .DATA_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .rfifo_empty (rfifo_empty),
    .rfifo_data  (rfifo_data),
    .rfifo_rd    (rfifo_rd),
    .rs232_tx    (rs232_tx),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
  endtask

  // Environment FIFO (standard read: data appears the cycle after the pop).
  logic [7:0] fifo_q[$];
  bit         rd_obs = 1'b0;

  // Reference model: each frame is described only by its decision cycle T and
  // its byte; every output is a closed-form function of (cycle - T).
  bit         chk_en     = 1'b0;
  bit         have_frame = 1'b0;
  int         ft         = 0;
  int         done_at    = -1;
  int         ready      = 0;
  logic [7:0] fbyte      = 8'h00;
  int         exp_done_n = 0;
  int         obs_done_n = 0;
  int         exp_rd_n   = 0;
  int         obs_rd_n   = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic step(input logic r, input logic en, input logic push, input logic [7:0] b);
    logic [3:0] exp_v;
    logic [3:0] got_v;
    logic       e_line, e_rd, e_busy, e_done;
    int         s;
    @(posedge clk);
    #1;
    if (rd_obs && fifo_q.size() > 0) rfifo_data = fifo_q.pop_front();
    if (push) fifo_q.push_back(b);
    rst         = r;
    tx_en       = en;
    rfifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
    rd_obs = rfifo_rd;

    e_line = 1'b1;
    e_rd   = 1'b0;
    e_busy = 1'b0;
    e_done = (cyc == done_at);
    if (have_frame) begin
      s      = ft + 3;
      e_rd   = (cyc == ft + 1);
      e_busy = (cyc >= ft + 1) && (cyc < s + 10 * B);
      if (cyc >= s && cyc < s + 10 * B) e_line = frame_bit(fbyte, (cyc - s) / B);
    end
    if (chk_en && (n_chk - n_pass) < 40) begin
      exp_v = {e_line, e_rd, e_busy, e_done};
      got_v = {rs232_tx, rfifo_rd, tx_busy, tx_done};
      check_val("line/rd/busy/done", int'(got_v), int'(exp_v));
      exp_done_n += int'(e_done);
      exp_rd_n   += int'(e_rd);
      obs_done_n += int'(tx_done);
      obs_rd_n   += int'(rfifo_rd);
      if (tx_done) $display("frame 0x%02h done at cycle %0d", fbyte, cyc);
    end

    if (r) begin
      have_frame = 1'b0;
      done_at    = -1;
      ready      = cyc + 1;
      chk_en     = 1'b1;
    end else if (cyc >= ready && en && fifo_q.size() > 0) begin
      have_frame = 1'b1;
      ft         = cyc;
      fbyte      = fifo_q[0];
      done_at    = cyc + 3 + 10 * B;
      ready      = done_at;
    end
    cyc++;
  endtask

  initial begin
    logic       en_r;
    logic       push_r;
    logic       rst_r;
    logic [3:0] rst_v;

    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    rst_v = {rs232_tx, rfifo_rd, tx_busy, tx_done};
    check_val("reset_state", int'(rst_v), 8);

    // Empty FIFO with permission: line stays high, no pops.
    repeat (600) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Single frame 0xAA.
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    repeat (10 * B + 20) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Back-to-back 0x10 then 0x55.
    step(1'b0, 1'b1, 1'b1, 8'h10);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    repeat (20 * B + 30) step(1'b0, 1'b1, 1'b0, 8'h00);

    // tx_en dropped during bit 4 with more data waiting.
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 1'b1, 8'hC3);
    repeat (4 * B + 2) step(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (25 * B) step(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (25 * B) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Reset during bit 5 of a 0xFF frame, then a normal frame.
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    repeat (2 + 5 * B + B / 2) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    repeat (12 * B) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Randomized traffic: bursty permission, random pushes, rare resets.
    en_r = 1'b1;
    repeat (6000) begin
      if ($urandom_range(0, 199) == 0) en_r = ~en_r;
      push_r = ($urandom_range(0, 99) == 0);
      rst_r  = ($urandom_range(0, 1999) == 0);
      step(rst_r, en_r, push_r, 8'($urandom));
    end

    // Drain whatever is left, bounded.
    for (int i = 0; i < 30000; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      if (fifo_q.size() == 0 && cyc > ready + 2) break;
    end
    check_val("drain_empty", fifo_q.size(), 0);
    check_val("done_count", obs_done_n, exp_done_n);
    check_val("rd_count", obs_rd_n, exp_rd_n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
